// File: rtl/s_pl_skid_buf_pkg.sv
// Shared types and constants for the s_pl_skid_buf elastic stage.
package s_pl_skid_buf_pkg;

    localparam int OCNT_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2,
        ST_ILL   = 2'd3
    } state_t;

    typedef struct packed {
        logic ld_main;
        logic ld_skid;
        logic mv_skid;
    } ld_t;

    function automatic logic [OCNT_W-1:0] occ_of(input state_t s);
        logic [OCNT_W-1:0] n;
        n = '0;
        case (s)
            ST_BUSY: n = OCNT_W'(1);
            ST_FULL: n = OCNT_W'(2);
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/s_pl_skid_buf_ctl.sv
// Skid-buffer control: state machine, registered handshake/occupancy
// outputs and load enables for the main/skid data entries.
module s_pl_skid_ctl
    import s_pl_skid_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic              i_ordy,
    output logic              o_irdy,
    output logic              o_ovld,
    output logic [OCNT_W-1:0] o_ocnt,
    output ld_t               o_ld
);

    state_t            r_state;
    logic              r_irdy;
    logic              r_ovld;
    logic [OCNT_W-1:0] r_ocnt;

    state_t w_nxt;
    ld_t    w_ld;
    logic   w_acc;
    logic   w_snd;

    assign w_acc = i_vld & r_irdy;
    assign w_snd = r_ovld & i_ordy;

    // Flush wins over everything and also suppresses data loads.
    always_comb begin
        w_nxt = r_state;
        w_ld  = '0;
        if (i_clr) begin
            w_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_nxt       = ST_BUSY;
                        w_ld.ld_main = 1'b1;
                    end
                end
                ST_BUSY: begin
                    case ({w_acc, w_snd})
                        2'b11: w_ld.ld_main = 1'b1;
                        2'b10: begin
                            w_nxt        = ST_FULL;
                            w_ld.ld_skid = 1'b1;
                        end
                        2'b01: w_nxt = ST_EMPTY;
                        default: w_nxt = ST_BUSY;
                    endcase
                end
                ST_FULL: begin
                    if (w_snd) begin
                        w_nxt        = ST_BUSY;
                        w_ld.mv_skid = 1'b1;
                    end
                end
                default: w_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_irdy  <= 1'b0;
            r_ovld  <= 1'b0;
            r_ocnt  <= '0;
        end else begin
            r_state <= w_nxt;
            r_irdy  <= (w_nxt != ST_FULL);
            r_ovld  <= (w_nxt == ST_BUSY) || (w_nxt == ST_FULL);
            r_ocnt  <= occ_of(w_nxt);
        end
    end

    assign o_irdy = r_irdy;
    assign o_ovld = r_ovld;
    assign o_ocnt = r_ocnt;
    assign o_ld   = w_ld;

endmodule

// File: rtl/s_pl_skid_buf.sv
// Two-entry elastic pipeline stage (main + skid) with registered ready,
// full 1 beat/cycle throughput and in-order delivery.
module s_pl_skid_buf
    import s_pl_skid_buf_pkg::*;
#(
    parameter int              SIZE    = 8,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iclr,
    input  logic            ivld,
    input  logic [SIZE-1:0] idat,
    output logic            irdy,
    output logic            ovld,
    output logic [SIZE-1:0] odat,
    input  logic            ordy,
    output logic [1:0]      ocnt
);

    logic [SIZE-1:0]   r_main;
    logic [SIZE-1:0]   r_skid;
    ld_t               w_ld;
    logic [OCNT_W-1:0] w_ocnt;

    s_pl_skid_ctl u_ctl (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (iclr),
        .i_vld  (ivld),
        .i_ordy (ordy),
        .o_irdy (irdy),
        .o_ovld (ovld),
        .o_ocnt (w_ocnt),
        .o_ld   (w_ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= RST_VAL;
            r_skid <= RST_VAL;
        end else begin
            if (w_ld.ld_main) begin
                r_main <= idat;
            end else if (w_ld.mv_skid) begin
                r_main <= r_skid;
            end
            if (w_ld.ld_skid) begin
                r_skid <= idat;
            end
        end
    end

    assign odat = r_main;
    assign ocnt = w_ocnt;

endmodule
